uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, oversampled start/data/parity/stop FSM, one-entry output buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_n;
  logic                   rx_meta, rx_sync, rx_prev;
  logic [TICK_W-1:0]      tick_cnt, tick_cnt_n;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   stop_hold, stop_hold_n;
  logic                   frame_done;
  logic                   frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad;
`endif

  // NOTE: every register uses non-blocking assignment so all flops update
  // together from the same pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_hold <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      stop_hold <= stop_hold_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    stop_hold_n = stop_hold;
    frame_done  = 1'b0;
    frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad  = 1'b0;
`endif

    unique case (state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n    = S_START;
          tick_cnt_n = '0;
        end
      end

      // Re-check the line mid-bit so short low glitches are rejected.
      S_START: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            state_n    = rx_sync ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            shreg_n    = {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n   = S_PARITY;
`else
              state_n   = S_STOP;
`endif
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            parity_bad = (rx_sync != (^shreg));
            state_n    = S_STOP;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
`endif

      // After a low stop bit, hold here until the line returns high.
      S_STOP: begin
        if (stop_hold) begin
          if (rx_sync) begin
            stop_hold_n = 1'b0;
            state_n     = S_IDLE;
          end
        end else if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            if (rx_sync) begin
              frame_done = 1'b1;
              state_n    = S_IDLE;
            end else begin
              frame_bad   = 1'b1;
              stop_hold_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n    = S_IDLE;
        tick_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_bad;
      overrun_err <= frame_done && rx_valid && !rx_ready;
      if (frame_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (8 data bits, 16x oversampling, baud_tick every 4 clocks).
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  logic       tick_en;
  int         div;
  int         total;
  int         bad;
  int         fe_cnt, ovr_cnt, pe_cnt, vld_cnt;
  int         f0, o0, p0, v0;
`ifdef UART_RX_PARITY_EN
  logic       par_flip;
`endif

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clock strobe every fourth clock, changed on the falling edge.
  always @(negedge clk) begin
    if (tick_en) begin
      div       = (div + 1) % 4;
      baud_tick = (div == 0);
    end else begin
      baud_tick = 1'b0;
    end
  end

  // High-cycle counters: a delta of 1 means exactly one one-clock pulse.
  always @(negedge clk) begin
    if (frame_err)   fe_cnt  = fe_cnt + 1;
    if (overrun_err) ovr_cnt = ovr_cnt + 1;
    if (parity_err)  pe_cnt  = pe_cnt + 1;
    if (rx_valid)    vld_cnt = vld_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the n-th rising edge that carries a baud tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  // Drives start, data (LSB first), optional parity and stop, then stops
  // 7 ticks into the stop bit, one tick before the receiver samples it.
  task automatic send_head(input logic [7:0] data, input logic stop, input int freeze_bit);
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int j = 0; j < 8; j++) begin
      rx = data[j];
      if (j == freeze_bit) begin
        wait_ticks(4);
        tick_en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        tick_en = 1'b1;
        wait_ticks(12);
      end else begin
        wait_ticks(16);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ par_flip;
    wait_ticks(16);
`endif
    rx = stop;
    wait_ticks(7);
  endtask

  task automatic send_frame(input logic [7:0] data);
    send_head(data, 1'b1, -1);
    wait_ticks(9);
  endtask

  task automatic snap;
    f0 = fe_cnt;
    o0 = ovr_cnt;
    p0 = pe_cnt;
    v0 = vld_cnt;
  endtask

  initial begin
    total = 0; bad = 0;
    fe_cnt = 0; ovr_cnt = 0; pe_cnt = 0; vld_cnt = 0;
    div = 0; baud_tick = 1'b0; tick_en = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_data", {24'b0, rx_data}, 32'h00);
    check("rst_errs", {29'b0, frame_err, overrun_err, parity_err}, 32'd0);
    reset = 1'b0;
    wait_ticks(4);

    // 0xA5 with rx_ready=1: rx_valid rises exactly one clock after the stop tick
    snap();
    send_head(8'hA5, 1'b1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("a5_pre_valid", {31'b0, rx_valid}, 32'd0);
    wait_ticks(1);
    check("a5_valid", {31'b0, rx_valid}, 32'd1);
    check("a5_data", {24'b0, rx_data}, 32'hA5);
    @(posedge clk);
    #1;
    check("a5_hs_clear", {31'b0, rx_valid}, 32'd0);
    wait_ticks(8);
    check("a5_no_err", fe_cnt + ovr_cnt + pe_cnt - f0 - o0 - p0, 32'd0);

    // 3-tick low glitch while idle
    snap();
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(24);
    check("glitch_valid", vld_cnt - v0, 32'd0);
    check("glitch_errs", fe_cnt + ovr_cnt + pe_cnt - f0 - o0 - p0, 32'd0);

    // 0x3C with low stop bit, line held low, then released
    snap();
    send_head(8'h3C, 1'b0, -1);
    wait_ticks(19);
    rx = 1'b1;
    wait_ticks(20);
    check("ferr_pulse", fe_cnt - f0, 32'd1);
    check("ferr_valid", vld_cnt - v0, 32'd0);

    // Next frame after a framing error
    snap();
    send_frame(8'h55);
    check("ferr_next_data", {24'b0, rx_data}, 32'h55);
    check("ferr_next_valid", vld_cnt - v0, 32'd1);

    // baud_tick held low mid-bit freezes the receiver
    snap();
    send_head(8'h6B, 1'b1, 3);
    wait_ticks(9);
    check("freeze_data", {24'b0, rx_data}, 32'h6B);
    check("freeze_errs", fe_cnt + ovr_cnt - f0 - o0, 32'd0);

    // Overrun: 0x11 held, 0x22 dropped
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11);
    check("ovr_first_valid", {31'b0, rx_valid}, 32'd1);
    check("ovr_first_data", {24'b0, rx_data}, 32'h11);
    send_frame(8'h22);
    check("ovr_pulse", ovr_cnt - o0, 32'd1);
    check("ovr_data_held", {24'b0, rx_data}, 32'h11);
    check("ovr_still_valid", {31'b0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_drain", {31'b0, rx_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Parity bit wrong, then right, on 0x07 (even parity bit = 1)
    snap();
    par_flip = 1'b1;
    send_frame(8'h07);
    check("par_bad_pulse", pe_cnt - p0, 32'd1);
    check("par_bad_data", {24'b0, rx_data}, 32'h07);
    check("par_bad_valid", vld_cnt - v0, 32'd1);
    snap();
    par_flip = 1'b0;
    send_frame(8'h07);
    check("par_ok_pulse", pe_cnt - p0, 32'd0);
    check("par_ok_valid", vld_cnt - v0, 32'd1);
`endif

    // Reset in the middle of bit 4 of 0xF0
    snap();
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int j = 0; j < 4; j++) begin
      rx = j[0] ? 1'b0 : 1'b0;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(8);
    reset = 1'b1;
    #1;
    check("mid_rst_data", {24'b0, rx_data}, 32'h00);
    check("mid_rst_outs", {28'b0, rx_valid, frame_err, overrun_err, parity_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ticks(60);
    check("mid_rst_no_valid", vld_cnt - v0, 32'd0);
    check("mid_rst_no_err", fe_cnt + ovr_cnt - f0 - o0, 32'd0);
    snap();
    send_frame(8'h81);
    check("post_rst_data", {24'b0, rx_data}, 32'h81);
    check("post_rst_valid", vld_cnt - v0, 32'd1);

`ifndef UART_RX_PARITY_EN
    check("parity_tied_low", pe_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
